// File: rtl/rpsc_pkg.sv
// Shared types for the RPSC power sequencer.
//   seq_state_t : sequencer state encoding (also exported on the state port)
//   FC_*        : latched fault cause codes, FC_NONE = no fault
package rpsc_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_G2_WAIT   = 3'd1,
    S_AN_SETTLE = 3'd2,
    S_DR_WAIT   = 3'd3,
    S_RUN       = 3'd4,
    S_RAMPDOWN  = 3'd5,
    S_FAULT     = 3'd6
  } seq_state_t;

  localparam logic [2:0] FC_NONE    = 3'd0;
  localparam logic [2:0] FC_ALARM1  = 3'd1;
  localparam logic [2:0] FC_ALARM2  = 3'd2;
  localparam logic [2:0] FC_G2_TMO  = 3'd3;
  localparam logic [2:0] FC_DR_TMO  = 3'd4;
  localparam logic [2:0] FC_G2_LOST = 3'd5;
  localparam logic [2:0] FC_DR_LOST = 3'd6;

endpackage

// File: rtl/seq_timer.sv
// Saturating dwell/timeout counter for the sequencer.
//   clk, reset : clock, async active-low reset
//   clr        : zero the count (state change)
//   en         : count this cycle (timed state)
//   target     : dwell/timeout length T in cycles
//   hit        : the coming edge is the T-th edge since the last clear
module seq_timer
  import rpsc_pkg::*;
#(
  parameter int TW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          en,
  input  logic [TW-1:0] target,
  output logic          hit
);

  localparam logic [TW:0] ONE = (TW+1)'(1);

  logic [TW-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

  // cnt holds the number of edges already spent in the state, so the
  // edge about to occur is edge cnt+1; widened so the +1 cannot wrap.
  assign hit = (({1'b0, cnt} + ONE) >= {1'b0, target});

endmodule

// File: rtl/rpsc_seq_ctrl.sv
// RPSC interlock power-up/power-down sequencer.
//   clk, reset      : clock, async active-low reset
//   start_req       : level power-up request (honoured only in IDLE)
//   stop_req        : level power-down request
//   fault_clr       : clear latched fault (honoured only in FAULT, alarms healthy)
//   not_alarm(2)    : section 1/2 healthy, 1 = healthy
//   ground_hold_ok  : start permissive
//   not_g2_ok       : 0 = G2 supply OK
//   not_dr_amp_ok   : 0 = driver amp OK
//   g2_ps_on, an_ps_on, dr_amp_on : registered supply enables
//   ready, fault    : in RUN / in FAULT
//   fault_code      : latched fault cause, 0 = none
//   state           : encoded current state
module rpsc_seq_ctrl
  import rpsc_pkg::*;
#(
  parameter int TW        = 8,
  parameter int G2_TMO    = 200,
  parameter int AN_SETTLE = 50,
  parameter int DR_TMO    = 100,
  parameter int OFF_DWELL = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_req,
  input  logic       stop_req,
  input  logic       fault_clr,
  input  logic       not_alarm,
  input  logic       ground_hold_ok,
  input  logic       not_g2_ok,
  input  logic       not_alarm2,
  input  logic       not_dr_amp_ok,
  output logic       g2_ps_on,
  output logic       an_ps_on,
  output logic       dr_amp_on,
  output logic       ready,
  output logic       fault,
  output logic [2:0] fault_code,
  output logic [2:0] state
);

  localparam int TMAX = (1 << TW) - 1;

  if ((G2_TMO > TMAX) || (AN_SETTLE > TMAX) || (DR_TMO > TMAX) || (OFF_DWELL > TMAX))
  begin : g_param_chk
    $error("rpsc_seq_ctrl: timing parameter exceeds 2^TW-1");
  end

  seq_state_t    cur, nxt;
  logic [2:0]    nxt_code;
  logic          tmr_en, tmr_hit;
  logic [TW-1:0] tmr_target;

  always_comb begin
    tmr_en     = 1'b1;
    tmr_target = '0;
    case (cur)
      S_G2_WAIT:   tmr_target = TW'(G2_TMO);
      S_AN_SETTLE: tmr_target = TW'(AN_SETTLE);
      S_DR_WAIT:   tmr_target = TW'(DR_TMO);
      S_RAMPDOWN:  tmr_target = TW'(OFF_DWELL);
      default:     tmr_en     = 1'b0;
    endcase
  end

  seq_timer #(.TW(TW)) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clr    (nxt != cur),
    .en     (tmr_en),
    .target (tmr_target),
    .hit    (tmr_hit)
  );

  // Priority in active states: alarms (lowest code first), RUN supply loss,
  // stop, then progress/timeout with "ready" beating a same-edge timeout.
  always_comb begin
    nxt      = cur;
    nxt_code = FC_NONE;
    case (cur)
      S_IDLE: begin
        if (start_req && ground_hold_ok && not_alarm && not_alarm2) nxt = S_G2_WAIT;
      end
      S_FAULT: begin
        if (fault_clr && not_alarm && not_alarm2) nxt = S_IDLE;
      end
      S_G2_WAIT, S_AN_SETTLE, S_DR_WAIT, S_RUN, S_RAMPDOWN: begin
        if (!not_alarm) begin
          nxt = S_FAULT; nxt_code = FC_ALARM1;
        end else if (!not_alarm2) begin
          nxt = S_FAULT; nxt_code = FC_ALARM2;
        end else if ((cur == S_RUN) && not_g2_ok) begin
          nxt = S_FAULT; nxt_code = FC_G2_LOST;
        end else if ((cur == S_RUN) && not_dr_amp_ok) begin
          nxt = S_FAULT; nxt_code = FC_DR_LOST;
        end else if ((cur != S_RAMPDOWN) && stop_req) begin
          nxt = S_RAMPDOWN;
        end else begin
          case (cur)
            S_G2_WAIT: begin
              if (!not_g2_ok)   nxt = S_AN_SETTLE;
              else if (tmr_hit) begin nxt = S_FAULT; nxt_code = FC_G2_TMO; end
            end
            S_AN_SETTLE: if (tmr_hit) nxt = S_DR_WAIT;
            S_DR_WAIT: begin
              if (!not_dr_amp_ok) nxt = S_RUN;
              else if (tmr_hit)   begin nxt = S_FAULT; nxt_code = FC_DR_TMO; end
            end
            S_RAMPDOWN: if (tmr_hit) nxt = S_IDLE;
            default: ;
          endcase
        end
      end
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur        <= S_IDLE;
      g2_ps_on   <= 1'b0;
      an_ps_on   <= 1'b0;
      dr_amp_on  <= 1'b0;
      ready      <= 1'b0;
      fault      <= 1'b0;
      fault_code <= FC_NONE;
    end else begin
      cur        <= nxt;
      g2_ps_on   <= nxt inside {S_G2_WAIT, S_AN_SETTLE, S_DR_WAIT, S_RUN, S_RAMPDOWN};
      an_ps_on   <= nxt inside {S_AN_SETTLE, S_DR_WAIT, S_RUN, S_RAMPDOWN};
      dr_amp_on  <= nxt inside {S_DR_WAIT, S_RUN};
      ready      <= (nxt == S_RUN);
      fault      <= (nxt == S_FAULT);
      if ((nxt == S_FAULT) && (cur != S_FAULT)) fault_code <= nxt_code;
      else if ((cur == S_FAULT) && (nxt == S_IDLE)) fault_code <= FC_NONE;
    end
  end

  assign state = cur;

endmodule

// File: doc/rpsc_seq_ctrl.md
# rpsc_seq_ctrl

Power-up/power-down sequencer for the RPSC interlock card. It takes the card's alarm and status outputs (Not_Alarm, Ground_Hold_OK, Not_G2_OK, Not_DR_AMP_OK, second-section Not_Alarm) and drives the G2 supply, anode supply and driver-amplifier enables in a fixed, timed order. It trips all enables on any interlock fault and latches a fault code until the operator clears it. It sits between the operator command interface and the supply enable lines.

## Interface
Parameters:
- `TW`, 8 — timer counter width.
- `G2_TMO`, 200 — cycles allowed for G2 OK after G2 enable.
- `AN_SETTLE`, 50 — anode settle dwell in cycles.
- `DR_TMO`, 100 — cycles allowed for driver amp OK after driver enable.
- `OFF_DWELL`, 20 — cycles anode/G2 are held after driver-off on a normal stop.

Ports:
- `clk` in 1 — single clock.
- `reset` in 1 — asynchronous, active-low.
- `start_req` in 1 — level; request power-up.
- `stop_req` in 1 — level; request power-down.
- `fault_clr` in 1 — clear latched fault.
- `not_alarm` in 1 — section-1 healthy (1 = healthy).
- `ground_hold_ok` in 1 — start permissive.
- `not_g2_ok` in 1 — 0 = G2 supply OK.
- `not_alarm2` in 1 — section-2 healthy.
- `not_dr_amp_ok` in 1 — 0 = driver amp OK.
- `g2_ps_on` out 1 — G2 supply enable.
- `an_ps_on` out 1 — anode supply enable.
- `dr_amp_on` out 1 — driver amplifier enable.
- `ready` out 1 — sequence complete, in RUN.
- `fault` out 1 — in FAULT.
- `fault_code` out 3 — latched cause; 0 = none.
- `state` out 3 — encoded current state, for diagnostics.

## Operation
- States: IDLE, G2_WAIT, AN_SETTLE, DR_WAIT, RUN, RAMPDOWN, FAULT.
- Outputs are registered Moore decodes of the state:
  - `g2_ps_on` in G2_WAIT through RUN and in RAMPDOWN.
  - `an_ps_on` in AN_SETTLE through RUN and in RAMPDOWN.
  - `dr_amp_on` in DR_WAIT and RUN only.
- IDLE → G2_WAIT when `start_req & ground_hold_ok & not_alarm & not_alarm2`.
- G2_WAIT → AN_SETTLE when `not_g2_ok==0`. If G2_TMO cycles elapse first, go to FAULT with code 3.
- AN_SETTLE → DR_WAIT after exactly AN_SETTLE cycles in the state.
- DR_WAIT → RUN when `not_dr_amp_ok==0`. If DR_TMO cycles elapse first, go to FAULT with code 4.
- RUN:
  - `not_g2_ok==1` → FAULT, code 5.
  - `not_dr_amp_ok==1` → FAULT, code 6.
- `stop_req` in G2_WAIT..RUN → RAMPDOWN. RAMPDOWN → IDLE after OFF_DWELL cycles.
- Alarms are checked in every state except IDLE and FAULT:
  - `not_alarm==0` → FAULT, code 1.
  - `not_alarm2==0` → FAULT, code 2.
  - These checks also apply during RAMPDOWN.
- Priority when events coincide: fault > stop > progress/timeout. Among simultaneous faults, the lowest code wins.
- FAULT → IDLE on `fault_clr` only when `not_alarm & not_alarm2`. `fault_code` returns to 0 on that transition.
- `fault_clr` outside FAULT has no effect. `start_req` outside IDLE is ignored.
- `start_req` still high on return to IDLE restarts the sequence; it is level-sensitive by design.

## Timing
- Reset value of every output is 0; state is IDLE and the timer is 0.
- Reset assertion mid-sequence drops all enables asynchronously.
- Inputs are sampled at a rising edge; the resulting state and outputs change at that edge. Latency is 1 cycle from input to enable.
- Timer:
  - Clears on every state change.
  - Increments once per cycle in a timed state.
  - A timeout of T fires on the T-th edge after state entry, so a state with T=4 is occupied for exactly 4 cycles.
- A ready condition and a timeout on the same edge: ready wins.
- Timer arithmetic is unsigned TW bits and saturates, never wrapping. Every timing parameter must be ≤ 2^TW−1; this is checked by an elaboration assertion.
- FAULT entry clears all three enables on the same edge.

## Structure
- Shared package `rpsc_pkg`: state enum `seq_state_t`, fault code constants `FC_NONE`..`FC_DR_LOST`.
- One sub-module, `seq_timer`: clear/enable/saturating counter with a `hit(T)` compare. The FSM instantiates one instance and muxes the target per state.

## Test plan
All scenarios use G2_TMO=10, AN_SETTLE=4, DR_TMO=6, OFF_DWELL=3.

- Nominal power-up:
  - Stimulus: start at cycle 0, `not_g2_ok` low at cycle 3, `not_dr_amp_ok` low at cycle 9.
  - Required: `g2_ps_on`=1 @1, `an_ps_on`=1 @4, `dr_amp_on`=1 @8, `ready`=1 @10.
- G2 timeout:
  - Stimulus: start, keep `not_g2_ok`=1.
  - Required: FAULT with `fault_code`=3 on the 10th edge after entering G2_WAIT, all enables 0.
- Alarm in RUN:
  - Stimulus: from RUN, drop `not_alarm2`.
  - Required: next edge FAULT, code 2, enables 0.
  - Follow-up: `fault_clr` while `not_alarm2`=0 stays in FAULT; once healthy, `fault_clr` → IDLE, code 0.
- Normal stop:
  - Stimulus: `stop_req` in RUN.
  - Required: `dr_amp_on`=0 next edge, `g2_ps_on`/`an_ps_on` held for 3 cycles, then IDLE.
- Simultaneous events:
  - Stimulus: in DR_WAIT, `stop_req` and `not_alarm`=0 on the same edge.
  - Required: FAULT code 1, not RAMPDOWN.
- Async reset:
  - Stimulus: assert `reset`=0 mid-AN_SETTLE.
  - Required: all outputs 0 immediately, without waiting for a clock edge.
